// File: rtl/xadc_sched_pkg.sv
// Shared types and constants for the XADC DRP scheduler.
// The auxiliary-channel address map is fixed for four channels.
package xadc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN_WAIT,
    HOST_WAIT,
    HOST_DONE
  } sched_state_t;

  localparam int unsigned MAP_CH = 4;
  localparam logic [6:0] CH_ADDR [MAP_CH] = '{7'h1E, 7'h17, 7'h1F, 7'h16};

  localparam int unsigned DEF_DATA_W  = 12;
  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/xadc_ch_rotator.sv
// Registered round-robin channel pointer. cur is the pointer itself; nxt is the
// first enabled channel at or after it, i.e. the channel a scan would read now.
module xadc_ch_rotator #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [NUM_CH-1:0]                      ch_enable,
  input  logic                                   load,
  input  logic                                   advance,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] nxt
);

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] step;
  logic [IW-1:0] idx;
  logic          found_nxt;
  logic          found_step;

  assign cur = ptr;

  // nxt searches from the pointer inclusive; step searches strictly past it,
  // with k == NUM_CH landing back on the pointer when it is the only one enabled.
  always_comb begin
    nxt        = ptr;
    step       = IW'((32'(ptr) + 32'd1) % NUM_CH);
    idx        = '0;
    found_nxt  = 1'b0;
    found_step = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = IW'((32'(ptr) + k) % NUM_CH);
      if (!found_nxt && ch_enable[idx]) begin
        nxt       = idx;
        found_nxt = 1'b1;
      end
    end
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = IW'((32'(ptr) + k) % NUM_CH);
      if (!found_step && ch_enable[idx]) begin
        step       = idx;
        found_step = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= nxt;
    end else if (advance) begin
      ptr <= step;
    end
  end

endmodule

// File: rtl/xadc_drp_scheduler.sv
// XADC DRP sequencer/arbiter: round-robin auxiliary channel scan on eoc plus a
// fixed-priority host port, one DRP access in flight at a time with timeout.
module xadc_drp_scheduler #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DATA_W  = xadc_sched_pkg::DEF_DATA_W,
  parameter int unsigned TIMEOUT = xadc_sched_pkg::DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     eoc,
  output logic                     drp_den,
  output logic                     drp_dwe,
  output logic [6:0]               drp_daddr,
  output logic [15:0]              drp_di,
  input  logic [15:0]              drp_do,
  input  logic                     drp_drdy,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [6:0]               host_addr,
  input  logic [15:0]              host_wdata,
  output logic                     host_ack,
  output logic [15:0]              host_rdata,
  output logic [NUM_CH*DATA_W-1:0] sample_data,
  output logic [NUM_CH-1:0]        sample_valid,
  output logic                     timeout_err
);

  import xadc_sched_pkg::*;

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  sched_state_t  state;
  sched_state_t  state_nx;
  logic          scan_pend;
  logic [CW-1:0] wait_cnt;
  logic [IW-1:0] cur_ch;
  logic [IW-1:0] nxt_ch;
  logic          in_wait;
  logic          expire;
  logic          launch_host;
  logic          launch_scan;
  logic          scan_done;
  logic          scan_abort;
  logic          host_done;
  logic          host_abort;

  xadc_ch_rotator #(
    .NUM_CH (NUM_CH)
  ) u_rotator (
    .clk       (clk),
    .resetn    (resetn),
    .ch_enable (ch_enable),
    .load      (launch_scan),
    .advance   (scan_done | scan_abort),
    .cur       (cur_ch),
    .nxt       (nxt_ch)
  );

  assign in_wait = (state == SCAN_WAIT) || (state == HOST_WAIT);
  assign expire  = in_wait && !drp_drdy && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (host_req) begin
          state_nx = HOST_WAIT;
        end else if (scan_pend && (ch_enable != '0)) begin
          state_nx = SCAN_WAIT;
        end
      end
      SCAN_WAIT: if (drp_drdy || expire) state_nx = IDLE;
      HOST_WAIT: if (drp_drdy || expire) state_nx = HOST_DONE;
      HOST_DONE: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    launch_host = 1'b0;
    launch_scan = 1'b0;
    scan_done   = 1'b0;
    scan_abort  = 1'b0;
    host_done   = 1'b0;
    host_abort  = 1'b0;
    unique case (state)
      IDLE: begin
        launch_host = host_req;
        launch_scan = !host_req && scan_pend && (ch_enable != '0);
      end
      SCAN_WAIT: begin
        scan_done  = drp_drdy;
        scan_abort = expire;
      end
      HOST_WAIT: begin
        host_done  = drp_drdy;
        host_abort = expire;
      end
      default: ;
    endcase
  end

  // A fresh eoc wins over the clear so an eoc landing on a launch is not lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_pend <= 1'b0;
    end else if (eoc) begin
      scan_pend <= 1'b1;
    end else if (launch_scan || ((state == IDLE) && (ch_enable == '0))) begin
      scan_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (launch_host || launch_scan) begin
      wait_cnt <= '0;
    end else if (in_wait && !drp_drdy && !expire) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drp_den      <= 1'b0;
      drp_dwe      <= 1'b0;
      drp_daddr    <= '0;
      drp_di       <= '0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      sample_data  <= '0;
      sample_valid <= '0;
      timeout_err  <= 1'b0;
    end else begin
      drp_den      <= 1'b0;
      host_ack     <= 1'b0;
      sample_valid <= '0;
      if (launch_host) begin
        drp_den   <= 1'b1;
        drp_dwe   <= host_we;
        drp_daddr <= host_addr;
        drp_di    <= host_wdata;
      end else if (launch_scan) begin
        drp_den   <= 1'b1;
        drp_dwe   <= 1'b0;
        drp_daddr <= CH_ADDR[nxt_ch];
        drp_di    <= '0;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (scan_done && (cur_ch == IW'(i))) begin
          sample_data[i*DATA_W +: DATA_W] <= drp_do[15 -: DATA_W];
          sample_valid[i]                 <= 1'b1;
        end
      end
      if (host_done) begin
        host_ack   <= 1'b1;
        host_rdata <= drp_do;
      end else if (host_abort) begin
        host_ack   <= 1'b1;
        host_rdata <= '0;
      end
      if (expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
